// File: rtl/phase_scheduler.sv
// Intersection phase sequencer: steps Main/Local approaches through green, yellow and
// all-red, and inserts an all-red WALK phase when pedestrian requests are pending.
module phase_scheduler #(
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned MAIN_GREEN  = 20,
  parameter int unsigned LOCAL_GREEN = 10,
  parameter int unsigned YELLOW      = 3,
  parameter int unsigned ALL_RED     = 1,
  parameter int unsigned WALK        = 8
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [3:0] ped_req,
  output logic [2:0] main_lights,
  output logic [2:0] local_lights,
  output logic [3:0] ped_walk,
  output logic       enable_L,
  output logic       enable_P,
  output logic [2:0] phase,
  output logic       tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

  localparam logic [2:0] LampR = 3'b100;
  localparam logic [2:0] LampY = 3'b010;
  localparam logic [2:0] LampG = 3'b001;

  typedef enum logic [2:0] {
    StMainGreen   = 3'd0,
    StMainYellow  = 3'd1,
    StAllRedM     = 3'd2,
    StLocalGreen  = 3'd3,
    StLocalYellow = 3'd4,
    StAllRedL     = 3'd5,
    StWalk        = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    t_q, t_d;
  logic [3:0]    pend_q, pend_d;
  logic [3:0]    walk_mask_q, walk_mask_d;
  logic [7:0]    dwell;
  logic          dwell_done;

  always_comb begin
    case (state_q)
      StMainGreen:   dwell = 8'(MAIN_GREEN);
      StMainYellow:  dwell = 8'(YELLOW);
      StAllRedM:     dwell = 8'(ALL_RED);
      StLocalGreen:  dwell = 8'(LOCAL_GREEN);
      StLocalYellow: dwell = 8'(YELLOW);
      StAllRedL:     dwell = 8'(ALL_RED);
      StWalk:        dwell = 8'(WALK);
      default:       dwell = 8'd1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q + PW'(1);
    t_d         = t_q;
    pend_d      = pend_q | ped_req;
    walk_mask_d = walk_mask_q;
    tick        = (presc_q == PrescMax);
    dwell_done  = tick && (t_q == dwell - 8'd1);

    if (tick) begin
      presc_d = '0;
      t_d     = t_q + 8'd1;
    end

    // Timing restarts on every transition so each dwell is independent of history.
    if (dwell_done) begin
      presc_d = '0;
      t_d     = '0;
      case (state_q)
        StMainGreen:   state_d = StMainYellow;
        StMainYellow:  state_d = StAllRedM;
        StAllRedM:     state_d = StLocalGreen;
        StLocalGreen:  state_d = StLocalYellow;
        StLocalYellow: state_d = StAllRedL;
        StAllRedL: begin
          if (pend_q != 4'b0) begin
            state_d     = StWalk;
            walk_mask_d = pend_q | ped_req;
            pend_d      = '0;
          end else begin
            state_d = StMainGreen;
          end
        end
        StWalk:        state_d = StMainGreen;
        default:       state_d = StAllRedL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q     <= StAllRedL;
      presc_q     <= '0;
      t_q         <= '0;
      pend_q      <= '0;
      walk_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      t_q         <= t_d;
      pend_q      <= pend_d;
      walk_mask_q <= walk_mask_d;
    end
  end

  always_comb begin
    main_lights  = LampR;
    local_lights = LampR;
    ped_walk     = 4'b0;
    enable_L     = 1'b1;
    enable_P     = 1'b0;
    phase        = state_q;
    case (state_q)
      StMainGreen:   main_lights  = LampG;
      StMainYellow:  main_lights  = LampY;
      StLocalGreen:  local_lights = LampG;
      StLocalYellow: local_lights = LampY;
      StWalk: begin
        ped_walk = walk_mask_q;
        enable_L = 1'b0;
        enable_P = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed self-checking bench for phase_scheduler with TICK_DIV=4 and default dwells.
module tb_phase_scheduler;

  localparam int unsigned TickDiv = 4;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic [3:0] ped_req = 4'b0;
  logic [2:0] main_lights, local_lights, phase;
  logic [3:0] ped_walk;
  logic       enable_L, enable_P, tick;

  int vectors = 0;
  int miscompares = 0;

  int         inv_cnt = 0;
  logic [2:0] inv_prev = 3'd5;

  phase_scheduler #(.TICK_DIV(TickDiv)) dut (
    .clk          (clk),
    .rst_a        (rst_a),
    .ped_req      (ped_req),
    .main_lights  (main_lights),
    .local_lights (local_lights),
    .ped_walk     (ped_walk),
    .enable_L     (enable_L),
    .enable_P     (enable_P),
    .phase        (phase),
    .tick         (tick)
  );

  always #5 clk = ~clk;

  // Continuous invariants: lamp decode per phase, strobes, walk gating, tick spacing.
  always @(negedge clk) begin : invariants
    logic [2:0] exp_main, exp_local;
    logic       exp_tick;
    if (!rst_a || phase != inv_prev) inv_cnt = 0;
    else inv_cnt++;
    inv_prev = phase;
    exp_tick = rst_a && ((inv_cnt % 4) == 3);
    case (phase)
      3'd0:    begin exp_main = 3'b001; exp_local = 3'b100; end
      3'd1:    begin exp_main = 3'b010; exp_local = 3'b100; end
      3'd2:    begin exp_main = 3'b100; exp_local = 3'b100; end
      3'd3:    begin exp_main = 3'b100; exp_local = 3'b001; end
      3'd4:    begin exp_main = 3'b100; exp_local = 3'b010; end
      3'd5:    begin exp_main = 3'b100; exp_local = 3'b100; end
      3'd6:    begin exp_main = 3'b100; exp_local = 3'b100; end
      default: begin exp_main = 3'b000; exp_local = 3'b000; end
    endcase
    vectors++;
    if ({main_lights, local_lights, enable_L, enable_P, tick} !==
        {exp_main, exp_local, (phase != 3'd6), (phase == 3'd6), exp_tick}) begin
      miscompares++;
      $display("FAIL invariant t=%0t phase=%0d got main=%b local=%b enL=%b enP=%b tick=%b, required main=%b local=%b enL=%b enP=%b tick=%b",
               $time, phase, main_lights, local_lights, enable_L, enable_P, tick,
               exp_main, exp_local, (phase != 3'd6), (phase == 3'd6), exp_tick);
    end
    vectors++;
    if (phase != 3'd6 && ped_walk !== 4'b0) begin
      miscompares++;
      $display("FAIL walk_gating t=%0t phase=%0d ped_walk=%b required 0000", $time, phase,
               ped_walk);
    end
    vectors++;
    if (main_lights !== 3'b100 && local_lights !== 3'b100) begin
      miscompares++;
      $display("FAIL conflict t=%0t main=%b local=%b required at least one 100", $time,
               main_lights, local_lights);
    end
  end

  // Counts consecutive negedge samples holding the current phase.
  task automatic measure(output logic [2:0] ph, output int n);
    ph = phase;
    n  = 0;
    while (phase === ph && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Returns the phase reached when the target appears or the bound expires.
  task automatic wait_phase(input logic [2:0] target, input int bound,
                            output logic [2:0] reached);
    int n = 0;
    while (phase !== target && n < bound) begin
      @(negedge clk);
      n++;
    end
    reached = phase;
  endtask

  task automatic test_reset();
    rst_a   = 1'b0;
    ped_req = 4'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({main_lights, local_lights, ped_walk, enable_L, enable_P, phase, tick} !==
        {3'b100, 3'b100, 4'b0000, 1'b1, 1'b0, 3'd5, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs got main=%b local=%b walk=%b enL=%b enP=%b phase=%0d tick=%b, required 100 100 0000 1 0 5 0",
               main_lights, local_lights, ped_walk, enable_L, enable_P, phase, tick);
    end
    #1 rst_a = 1'b1;
  endtask

  task automatic test_idle_sequence();
    logic [2:0] exp_ph [6] = '{3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    int         exp_len[6] = '{4, 80, 12, 4, 40, 12};
    logic [2:0] ph;
    int         n;
    for (int i = 0; i < 6; i++) begin
      measure(ph, n);
      vectors++;
      if (ph !== exp_ph[i] || n != exp_len[i]) begin
        miscompares++;
        $display("FAIL idle_seq[%0d] got phase=%0d len=%0d, required phase=%0d len=%0d", i,
                 ph, n, exp_ph[i], exp_len[i]);
      end
    end
    vectors++;
    if (phase !== 3'd5) begin
      miscompares++;
      $display("FAIL idle_end got phase=%0d required 5", phase);
    end
  endtask

  task automatic test_single_press();
    logic [2:0] r, ph;
    int         n;
    wait_phase(3'd0, 50, r);
    repeat (5) @(negedge clk);
    ped_req = 4'b0001;
    @(negedge clk);
    ped_req = 4'b0000;
    wait_phase(3'd6, 400, r);
    vectors++;
    if (r !== 3'd6 || {ped_walk, enable_P, enable_L} !== {4'b0001, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_press_walk got phase=%0d walk=%b enP=%b enL=%b, required 6 0001 1 0",
               r, ped_walk, enable_P, enable_L);
    end
    measure(ph, n);
    vectors++;
    if (n != 32 || phase !== 3'd0) begin
      miscompares++;
      $display("FAIL single_press_len got len=%0d next=%0d, required len=32 next=0", n, phase);
    end
    wait_phase(3'd5, 400, r);
    measure(ph, n);
    vectors++;
    if (ph !== 3'd5 || n != 4 || phase !== 3'd0) begin
      miscompares++;
      $display("FAIL single_press_cleared got phase=%0d len=%0d next=%0d, required 5 4 0", ph,
               n, phase);
    end
  endtask

  task automatic test_transition_press();
    logic [2:0] r, ph;
    int         n;
    ped_req = 4'b0100;
    @(negedge clk);
    ped_req = 4'b0000;
    wait_phase(3'd5, 400, r);
    repeat (3) @(negedge clk);
    ped_req = 4'b1000;
    @(negedge clk);
    ped_req = 4'b0000;
    vectors++;
    if (phase !== 3'd6 || ped_walk !== 4'b1100) begin
      miscompares++;
      $display("FAIL transition_press got phase=%0d walk=%b, required phase=6 walk=1100",
               phase, ped_walk);
    end
    measure(ph, n);
    vectors++;
    if (n != 32 || phase !== 3'd0) begin
      miscompares++;
      $display("FAIL transition_walk_len got len=%0d next=%0d, required 32 0", n, phase);
    end
    wait_phase(3'd5, 400, r);
    measure(ph, n);
    vectors++;
    if (n != 4 || phase !== 3'd0) begin
      miscompares++;
      $display("FAIL transition_no_rewalk got len=%0d next=%0d, required 4 0", n, phase);
    end
  endtask

  task automatic test_press_during_walk();
    logic [2:0] r;
    int         n;
    ped_req = 4'b0001;
    @(negedge clk);
    ped_req = 4'b0000;
    wait_phase(3'd6, 400, r);
    repeat (10) @(negedge clk);
    ped_req = 4'b0010;
    @(negedge clk);
    ped_req = 4'b0000;
    repeat (3) @(negedge clk);
    vectors++;
    if (phase !== 3'd6 || ped_walk !== 4'b0001) begin
      miscompares++;
      $display("FAIL walk_press_hold got phase=%0d walk=%b, required phase=6 walk=0001",
               phase, ped_walk);
    end
    wait_phase(3'd0, 100, r);
    n = 0;
    while (phase !== 3'd6 && n < 400) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n != 152 || phase !== 3'd6 || ped_walk !== 4'b0010) begin
      miscompares++;
      $display("FAIL walk_press_served got cycles=%0d phase=%0d walk=%b, required 152 6 0010",
               n, phase, ped_walk);
    end
  endtask

  task automatic test_async_reset_walk();
    logic [2:0] r, ph;
    int         n;
    repeat (2) @(negedge clk);
    ped_req = 4'b0100;
    @(negedge clk);
    ped_req = 4'b0000;
    @(posedge clk);
    #2 rst_a = 1'b0;
    #1;
    vectors++;
    if ({main_lights, local_lights, ped_walk, enable_L, enable_P, phase, tick} !==
        {3'b100, 3'b100, 4'b0000, 1'b1, 1'b0, 3'd5, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset got main=%b local=%b walk=%b enL=%b enP=%b phase=%0d tick=%b, required 100 100 0000 1 0 5 0",
               main_lights, local_lights, ped_walk, enable_L, enable_P, phase, tick);
    end
    @(negedge clk);
    #1 rst_a = 1'b1;
    measure(ph, n);
    vectors++;
    if (ph !== 3'd5 || n != 4 || phase !== 3'd0) begin
      miscompares++;
      $display("FAIL post_reset_first got phase=%0d len=%0d next=%0d, required 5 4 0", ph, n,
               phase);
    end
    wait_phase(3'd5, 400, r);
    measure(ph, n);
    vectors++;
    if (ph !== 3'd5 || n != 4 || phase !== 3'd0) begin
      miscompares++;
      $display("FAIL post_reset_no_walk got phase=%0d len=%0d next=%0d, required 5 4 0", ph,
               n, phase);
    end
  endtask

  initial begin
    test_reset();
    test_idle_sequence();
    test_single_press();
    test_transition_press();
    test_press_during_walk();
    test_async_reset_walk();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
